// File: rtl/tport_pkg.sv
// Shared constants, FSM state type and byte-order helper for the test-port capture block.
package tport_pkg;

  localparam logic [29:0] DEF_TEST_PORT = 30'h3FF;
  localparam logic [31:0] DEF_BEGIN_SYM = 32'h0000_0168;
  localparam logic [31:0] DEF_END_SYM   = 32'hFFFF_FD5D;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Bus data is little-endian; the checker wants the most significant byte first.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is accepted only
// when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so the stream outputs read 0 out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; when full with a pop this overwrites the slot being read out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/tport_capture.sv
// Test-port store capture: de-duplicates stalled stores, frames a session between the
// begin/end symbols, buffers byte-swapped words and exports session statistics.
module tport_capture
  import tport_pkg::*;
#(
  parameter logic [29:0] TEST_PORT = DEF_TEST_PORT,
  parameter logic [31:0] BEGIN_SYM = DEF_BEGIN_SYM,
  parameter logic [31:0] END_SYM   = DEF_END_SYM,
  parameter int          DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] addr,
  input  logic [31:0] data,
  input  logic        wen,
  input  logic        tp_ready,
  output logic        tp_valid,
  output logic [31:0] tp_data,
  output logic        tp_last,
  output logic        active,
  output logic        done,
  output logic [9:0]  word_cnt,
  output logic [15:0] cycles,
  output logic        overflow
);

  // Stream handshake: a word transfers on every cycle where tp_valid && tp_ready;
  // while tp_valid is high and tp_ready low, tp_data/tp_last stay unchanged.

  state_t      state;
  logic        wen_q;
  logic [29:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] rd;
  logic        store_evt;
  logic        push_req;
  logic        push_ok;
  logic        push_drop;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [32:0] head;

  assign rd        = byte_swap(data);
  assign store_evt = wen && (addr == TEST_PORT) &&
                     (!wen_q || (addr != addr_q) || (data != data_q));
  assign pop       = tp_valid && tp_ready;
  assign push_req  = (state == CAPTURE) && store_evt;
  assign push_ok   = push_req && (!fifo_full || pop);
  assign push_drop = push_req && fifo_full && !pop;

  assign tp_valid = !fifo_empty;
  assign tp_data  = head[31:0];
  assign tp_last  = head[32];

  // Previous-cycle bus snapshot for the stall de-duplication compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wen_q  <= wen;
      addr_q <= addr;
      data_q <= data;
    end
  end

  // Session FSM with registered status flags, counters and the sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      active   <= 1'b0;
      done     <= 1'b0;
      word_cnt <= '0;
      cycles   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (store_evt && (rd == BEGIN_SYM)) begin
            state    <= CAPTURE;
            active   <= 1'b1;
            word_cnt <= '0;
            cycles   <= '0;
          end
        end
        CAPTURE: begin
          if (cycles != 16'hFFFF) cycles <= cycles + 16'd1;
          if (push_ok && (word_cnt != 10'h3FF)) word_cnt <= word_cnt + 10'd1;
          if (push_drop) overflow <= 1'b1;
          // The end symbol closes the session even when its push was dropped.
          if (push_req && (rd == END_SYM)) begin
            state  <= DONE;
            active <= 1'b0;
            done   <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (33),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .push_data ({(rd == END_SYM), rd}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_tport_capture.sv
// Bench for tport_capture: directed scenarios plus randomized sessions against a
// queue-based reference model; a monitor compares every transferred word.
module tb_tport_capture;

  localparam logic [29:0] TP      = 30'h3FF;
  localparam logic [31:0] BEGIN_W = 32'h0000_0168;
  localparam logic [31:0] END_W   = 32'hFFFF_FD5D;
  localparam int          DEPTH   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] data = '0;
  logic        wen = 1'b0;
  logic        tp_ready = 1'b0;
  logic        tp_valid;
  logic [31:0] tp_data;
  logic        tp_last;
  logic        active;
  logic        done;
  logic [9:0]  word_cnt;
  logic [15:0] cycles;
  logic        overflow;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tport_capture #(
    .TEST_PORT (TP),
    .BEGIN_SYM (BEGIN_W),
    .END_SYM   (END_W),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data     (data),
    .wen      (wen),
    .tp_ready (tp_ready),
    .tp_valid (tp_valid),
    .tp_data  (tp_data),
    .tp_last  (tp_last),
    .active   (active),
    .done     (done),
    .word_cnt (word_cnt),
    .cycles   (cycles),
    .overflow (overflow)
  );

  // ---------------- scoreboard state / reference model ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [32:0] exp_q[$];

  bit          m_open;
  bit          m_closed;
  bit          m_overflow;
  int          m_occ;
  int          m_word_cnt;
  int          m_cycles;
  bit          p_wen;
  logic [29:0] p_addr;
  logic [31:0] p_data;

  // Byte reversal written arithmetically; converts readable <-> bus order both ways.
  function automatic logic [31:0] to_bus(input logic [31:0] w);
    return ((w & 32'h0000_00FF) << 24) | ((w & 32'h0000_FF00) << 8) |
           ((w >> 8) & 32'h0000_FF00) | (w >> 24);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_open = 0; m_closed = 0; m_overflow = 0;
    m_occ = 0; m_word_cnt = 0; m_cycles = 0;
    p_wen = 0; p_addr = '0; p_data = '0;
  endtask

  // One clock of the reference behaviour, evaluated with the inputs of this cycle.
  task automatic model_eval();
    logic [31:0] rd;
    bit          ev;
    bit          pop;
    bit          took;
    rd   = to_bus(data);
    ev   = wen && (addr == TP) && (!p_wen || addr != p_addr || data != p_data);
    pop  = (m_occ > 0) && tp_ready;
    took = 0;
    if (m_open) begin
      if (m_cycles < 65535) m_cycles++;
      if (ev) begin
        if (m_occ < DEPTH || pop) begin
          exp_q.push_back({rd == END_W, rd});
          took = 1;
          if (m_word_cnt < 1023) m_word_cnt++;
        end else begin
          m_overflow = 1;
        end
        if (rd == END_W) begin
          m_open = 0;
          m_closed = 1;
        end
      end
    end else if (!m_closed && ev && rd == BEGIN_W) begin
      m_open = 1;
      m_cycles = 0;
      m_word_cnt = 0;
    end
    m_occ = m_occ + int'(took) - int'(pop);
    p_wen = wen; p_addr = addr; p_data = data;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit w, input logic [29:0] a, input logic [31:0] d, input bit r);
    wen = w; addr = a; data = d; tp_ready = r;
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  // Single store of a readable word followed by one idle bus cycle.
  task automatic store(input logic [31:0] rd_word, input bit r);
    cycle(1'b1, TP, to_bus(rd_word), r);
    cycle(1'b0, TP, to_bus(rd_word), r);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    wen = 1'b0; addr = '0; data = '0; tp_ready = 1'b0;
    model_reset();
    #1;
    check({tag, ".tp_valid"}, 32'(tp_valid), 32'(0));
    check({tag, ".tp_data"},  tp_data,       32'(0));
    check({tag, ".tp_last"},  32'(tp_last),  32'(0));
    check({tag, ".active"},   32'(active),   32'(0));
    check({tag, ".done"},     32'(done),     32'(0));
    check({tag, ".word_cnt"}, 32'(word_cnt), 32'(0));
    check({tag, ".cycles"},   32'(cycles),   32'(0));
    check({tag, ".overflow"}, 32'(overflow), 32'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".active"},   32'(active),   32'(m_open));
    check({tag, ".done"},     32'(done),     32'(m_closed));
    check({tag, ".word_cnt"}, 32'(word_cnt), 32'(m_word_cnt));
    check({tag, ".cycles"},   32'(cycles),   32'(m_cycles));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_overflow));
  endtask

  // Bounded drain with tp_ready high; every expected word must have been seen.
  task automatic drain(input string tag);
    for (int i = 0; i < 100 && m_occ > 0; i++) cycle(1'b0, TP, 32'h0, 1'b1);
    check({tag, ".drained"}, 32'(exp_q.size()), 32'(0));
    check({tag, ".tp_valid"}, 32'(tp_valid), 32'(0));
  endtask

  // ---------------- monitor ----------------
  bit          hold = 0;
  logic [32:0] held = '0;

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      if (hold) begin
        n_checks++;
        if (tp_valid && {tp_last, tp_data} === held) n_pass++;
        else $display("FAIL hold_stable: got valid=%0b word=%0h required %0h",
                      tp_valid, {tp_last, tp_data}, held);
      end
      if (tp_valid && tp_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL stream_word: got %0h required no word", {tp_last, tp_data});
        end else begin
          e = exp_q.pop_front();
          if ({tp_last, tp_data} === e) n_pass++;
          else $display("FAIL stream_word: got %0h required %0h", {tp_last, tp_data}, e);
        end
      end
      hold = tp_valid && !tp_ready;
      held = {tp_last, tp_data};
    end else begin
      hold = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    int          r;
    bit          rdy;

    // Session 1: ignored stores, basic framed stream, ignored stores after close.
    do_reset("reset0");
    cycle(1'b1, 30'h3FE, to_bus(BEGIN_W), 1'b1);
    cycle(1'b0, 30'h3FE, 32'h0, 1'b1);
    store(32'h11, 1'b1);
    store(32'h22, 1'b1);
    check("pre_begin.active", 32'(active), 32'(0));
    check("pre_begin.tp_valid", 32'(tp_valid), 32'(0));
    check("pre_begin.word_cnt", 32'(word_cnt), 32'(m_word_cnt));
    store(BEGIN_W, 1'b1);
    check("begin.active", 32'(active), 32'(1));
    store(32'h0, 1'b1);
    store(32'h1, 1'b1);
    store(32'h2, 1'b1);
    store(END_W, 1'b1);
    drain("basic");
    check("basic.word_cnt4", 32'(word_cnt), 32'(4));
    check("basic.done1", 32'(done), 32'(1));
    check_status("basic");
    store(32'h55, 1'b1);
    store(BEGIN_W, 1'b1);
    drain("after_done");
    check_status("after_done");

    // Session 2: stall de-duplication and back-to-back distinct stores.
    do_reset("reset1");
    store(BEGIN_W, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, TP, to_bus(32'h5), 1'b1);
    cycle(1'b1, TP, to_bus(32'h7), 1'b1);
    cycle(1'b1, TP, to_bus(32'h8), 1'b1);
    cycle(1'b0, TP, 32'h0, 1'b1);
    drain("stall");
    check("stall.word_cnt3", 32'(word_cnt), 32'(3));
    check_status("stall");

    // Session 3: overflow with the consumer stalled, then ordered drain.
    do_reset("reset2");
    store(BEGIN_W, 1'b0);
    for (int i = 0; i < 9; i++) store(32'h100 + 32'(i), 1'b0);
    check("ovf.overflow1", 32'(overflow), 32'(1));
    check("ovf.word_cnt8", 32'(word_cnt), 32'(8));
    check("ovf.tp_valid", 32'(tp_valid), 32'(1));
    check_status("ovf");
    drain("ovf");
    store(END_W, 1'b1);
    drain("ovf_end");
    check_status("ovf_end");

    // Session 4: reset with words buffered, then a fresh session.
    do_reset("reset3");
    store(BEGIN_W, 1'b0);
    for (int i = 0; i < 3; i++) store(32'hA0 + 32'(i), 1'b0);
    check("mid.tp_valid", 32'(tp_valid), 32'(1));
    do_reset("reset_mid");
    store(BEGIN_W, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, TP, 32'h0, 1'b1);
    check("fresh.cycles5", 32'(cycles), 32'(5));
    check_status("fresh");

    // Randomized sessions: stalls, address misses, random back-pressure, rare symbols.
    for (int s = 0; s < 3; s++) begin
      do_reset("reset_rand");
      store(BEGIN_W, 1'b1);
      for (int i = 0; i < 300; i++) begin
        r = $urandom_range(0, 63);
        if (r == 0)      d = to_bus(END_W);
        else if (r == 1) d = to_bus(BEGIN_W);
        else if (r < 24) d = data;
        else             d = $urandom;
        rdy = ($urandom_range(0, s + 1) != 0);
        cycle(($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0) ? 30'h3FE : TP, d, rdy);
      end
      check_status("rand");
      drain("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
